adder_accumulator: RTL

Sequential accumulator stage directly downstream of the 4-bit ripple-carry adder. It drives the adder's operand and carry-in inputs, consumes its sum and carry-out, and registers a running result over a batch of operands. It also tracks a sticky carry/borrow overflow flag and the accepted-operand count, and pulses `done` when the batch length is reached. It is the register and control wrapper that turns the combinational adder into a multi-operand add/subtract unit.

---
 rtl/adder_accumulator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/adder_accumulator.sv
// adder_accumulator: register and control wrapper around an external
// combinational ripple-carry adder. Accumulates a batch of add/subtract
// operands, tracks a sticky unsigned carry/borrow flag and the accepted
// operand count, and pulses done when the batch length is reached.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; results from last batch are held
// RUN   | accepting operands, one per cycle when in_valid is high
// DONE  | one-cycle done pulse, then back to IDLE
module adder_accumulator #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic             sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic [WIDTH-1:0] acc,
    output logic             ovf,
    output logic [LEN_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_inc;
    logic             accept;
    logic             start_go;
    logic             last_accept;

    assign start_go    = (state == IDLE) && start;
    assign accept      = in_valid && in_ready;
    assign count_inc   = count + 1'b1;
    assign last_accept = accept && (count_inc == len_q);

    // Drive the external adder: subtraction is a + ~b + 1.
    always_comb begin
        add_a   = acc;
        add_b   = sub ? ~operand : operand;
        add_cin = sub;
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero-length batch goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded purely from state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers: cleared on start, updated together on each accept,
    // otherwise held so the last batch result stays visible in IDLE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            len_q <= '0;
        end else if (start_go) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            len_q <= len;
        end else if (accept) begin
            acc   <= add_s;
            // Carry-out on add, or missing carry-out (borrow) on subtract.
            ovf   <= ovf | (add_cout ^ sub);
            count <= count_inc;
        end
    end

endmodule
